// File: rtl/mux_8ch_rr_scheduler.sv
// 8-channel packet multiplexer: round-robin arbitration across enabled channels,
// with the grant held for a whole packet and released after its last beat.
module mux_8ch_rr_scheduler #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          in_valid,
  input  logic [8*DATA_W-1:0] in_data,
  input  logic [7:0]          in_last,
  output logic [7:0]          in_ready,
  input  logic [7:0]          chan_en,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [2:0]          sel,
  output logic [7:0]          grant
);

  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt, sel_nxt, pick;
  logic [N_CH-1:0]  grant_nxt, req;
  logic             pick_vld, pkt_done;

  assign req = in_valid & chan_en;

  // First requesting channel at or above ptr, wrapping 7 -> 0
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!pick_vld && req[SEL_W'(ptr + SEL_W'(k))]) begin
        pick     = SEL_W'(ptr + SEL_W'(k));
        pick_vld = 1'b1;
      end
    end
  end

  // Output path is a pure mux of the granted channel, no added latency
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_ready  = '0;
    out_data  = in_data[sel*DATA_W +: DATA_W];
    if (state == XFER) begin
      out_valid = in_valid[sel];
      out_last  = in_last[sel];
      in_ready  = out_ready ? (N_CH'(1) << sel) : '0;
    end
  end

  assign pkt_done = out_valid & out_ready & out_last;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          sel_nxt   = pick;
          grant_nxt = N_CH'(1) << pick;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (pkt_done) begin
          ptr_nxt   = SEL_W'(sel + 1'b1);
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      grant <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      grant <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_mux_8ch_rr_scheduler.sv
// Scoreboard bench for mux_8ch_rr_scheduler: packet-level sources, an abstract
// round-robin model predicting beats, and a monitor popping them on transfer.
module tb_mux_8ch_rr_scheduler;

  localparam int unsigned DATA_W = 8;

  typedef struct packed { logic [DATA_W-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [2:0] ch; logic [DATA_W-1:0] data; logic last; } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [7:0]          in_valid, in_last, in_ready, chan_en, grant;
  logic [8*DATA_W-1:0] in_data;
  logic                out_valid, out_last, out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [2:0]          sel;

  mux_8ch_rr_scheduler #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .chan_en(chan_en),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sel(sel), .grant(grant)
  );

  always #5 clk = ~clk;

  beat_t      src_q [8][$];
  exp_t       exp_q [$];
  int         grant_log [$];
  int         exp_log [$];
  int         gap [8];
  logic [7:0] en_r;
  int         ordy_mode;
  bit         m_busy;
  int         m_chan, m_ptr;
  int         checks = 0;
  int         errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void add_pkt(input int ch, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data = DATA_W'($urandom);
      b.last = (j == len - 1);
      src_q[ch].push_back(b);
    end
  endfunction

  function automatic void drop_packet(input int ch);
    beat_t b;
    while (src_q[ch].size() > 0) begin
      b = src_q[ch].pop_front();
      if (b.last) break;
    end
  endfunction

  function automatic bit all_idle();
    bit r = !m_busy;
    for (int i = 0; i < 8; i++) if (src_q[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  function automatic void check_log(input string nm);
    chk({nm, "_count"}, 32'(grant_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < grant_log.size(); i++)
      chk({nm, "_order"}, 32'(grant_log[i]), 32'(exp_log[i]));
    grant_log.delete();
    exp_log.delete();
  endfunction

  task automatic drive();
    logic [7:0]          v, l;
    logic [8*DATA_W-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < 8; i++) begin
      if (src_q[i].size() > 0 && gap[i] == 0) begin
        v[i] = 1'b1;
        l[i] = src_q[i][0].last;
        d[i*DATA_W +: DATA_W] = src_q[i][0].data;
      end else begin
        d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      if (gap[i] > 0) gap[i]--;
    end
    in_valid = v; in_last = l; in_data = d; chan_en = en_r;
    case (ordy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Abstract model: idle or busy on one channel; pick first requester from ptr
  task automatic model_step();
    logic [7:0] exp_gnt, exp_rdy, req;
    logic       exp_ov;
    int         c;
    exp_t       e;
    exp_gnt = m_busy ? 8'(1 << m_chan) : 8'h00;
    exp_rdy = (m_busy && out_ready) ? exp_gnt : 8'h00;
    exp_ov  = m_busy && in_valid[m_chan];
    chk("grant", 32'(grant), 32'(exp_gnt));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (m_busy) chk("sel", 32'(sel), 32'(m_chan));
    if (m_busy) begin
      if (in_valid[m_chan] && out_ready && src_q[m_chan].size() > 0 && src_q[m_chan][0].last) begin
        m_busy = 1'b0;
        m_ptr  = (m_chan + 1) % 8;
      end
    end else begin
      req = in_valid & chan_en;
      if (req != 8'h00) begin
        c = m_ptr;
        for (int k = 0; k < 8; k++) begin
          c = (m_ptr + k) % 8;
          if (req[c]) break;
        end
        m_busy = 1'b1;
        m_chan = c;
        for (int j = 0; j < src_q[c].size(); j++) begin
          e.ch = 3'(c); e.data = src_q[c][j].data; e.last = src_q[c][j].last;
          exp_q.push_back(e);
          if (src_q[c][j].last) break;
        end
      end
    end
    for (int i = 0; i < 8; i++)
      if (in_ready[i] && in_valid[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
  endtask

  task automatic tick(input bit rel = 1'b0);
    @(negedge clk);
    drive();
    if (rel) rst_n = 1'b1;
    #1;
    model_step();
  endtask

  task automatic assert_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    if (m_busy) drop_packet(m_chan);
    m_busy = 1'b0;
    m_ptr  = 0;
    exp_q.delete();
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, 32'(all_idle()), 32'd1);
    tick();
    chk({nm, "_exp_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_busy_on(input string nm, input int ch);
    int n = 0;
    while (!(m_busy && m_chan == ch) && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_granted"}, 32'(m_busy && m_chan == ch), 32'd1);
  endtask

  // Monitor: pop the predicted beat whenever the DUT transfers one
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual sel=%0d data=%0h required none @%0t", sel, out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_sel", 32'(sel), 32'(e.ch));
          chk("beat_data", 32'(out_data), 32'(e.data));
          chk("beat_last", 32'(out_last), 32'(e.last));
          if (out_last) grant_log.push_back(int'(sel));
        end
      end
    end
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog actual=running required=finished @%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ch;
    rst_n = 1'b1; in_valid = '0; in_last = '0; in_data = '0;
    en_r = 8'hFF; chan_en = 8'hFF; out_ready = 1'b1; ordy_mode = 0;
    m_busy = 1'b0; m_chan = 0; m_ptr = 0;
    for (int i = 0; i < 8; i++) gap[i] = 0;

    assert_reset();
    tick(1'b1);

    // Two requesters alternate, starting from channel 2 after reset
    for (int r = 0; r < 3; r++) begin
      add_pkt(2, 1); add_pkt(5, 1);
      exp_log.push_back(2); exp_log.push_back(5);
    end
    drain("rr_2_5", 100);
    check_log("rr_2_5");

    // Multi-beat packet under a toggling out_ready holds its grant
    ordy_mode = 1; out_ready = 1'b0;
    add_pkt(3, 4);
    tick();
    add_pkt(0, 1);
    exp_log.push_back(3); exp_log.push_back(0);
    drain("hold_ch3", 100);
    check_log("hold_ch3");
    ordy_mode = 0;

    // Full request set from ptr=0 gives strict 0..7 order twice
    assert_reset();
    tick(1'b1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) begin
        add_pkt(i, 1);
        exp_log.push_back(i);
      end
    drain("fair16", 200);
    check_log("fair16");

    // chan_en masks new grants only
    en_r = 8'h01;
    add_pkt(0, 1); add_pkt(0, 1); add_pkt(1, 1);
    repeat (12) tick();
    chk("masked_ch1_pending", 32'(src_q[1].size()), 32'd1);
    exp_log.push_back(0); exp_log.push_back(0);
    check_log("en_mask");
    add_pkt(0, 3);
    wait_busy_on("en_drop", 0);
    en_r = 8'h00;
    repeat (8) tick();
    chk("en_drop_pkt_done", 32'(src_q[0].size()), 32'd0);
    chk("en_drop_ch1_pending", 32'(src_q[1].size()), 32'd1);
    exp_log.push_back(0);
    check_log("en_drop");
    en_r = 8'hFF;
    exp_log.push_back(1);
    drain("en_restore", 50);
    check_log("en_restore");

    // Source gap mid-packet keeps the grant with out_valid low
    add_pkt(4, 5); add_pkt(7, 1);
    wait_busy_on("gap", 4);
    tick();
    gap[4] = 3;
    exp_log.push_back(4); exp_log.push_back(7);
    drain("gap", 100);
    check_log("gap");

    // Asynchronous reset during beat 2 abandons the packet
    assert_reset();
    tick(1'b1);
    add_pkt(6, 4);
    wait_busy_on("mid_rst", 6);
    tick();
    tick();
    assert_reset();
    grant_log.delete();
    add_pkt(6, 2); add_pkt(0, 1);
    tick(1'b1);
    exp_log.push_back(0); exp_log.push_back(6);
    drain("post_rst", 100);
    check_log("post_rst");

    // Randomized traffic, enables, gaps and backpressure
    ordy_mode = 2;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, 7);
        if (src_q[ch].size() < 6) add_pkt(ch, $urandom_range(1, 4));
      end
      if ($urandom_range(0, 7) == 0) en_r = 8'($urandom | $urandom);
      if ($urandom_range(0, 15) == 0) gap[$urandom_range(0, 7)] = $urandom_range(1, 3);
      tick();
    end
    en_r = 8'hFF;
    ordy_mode = 0;
    drain("random", 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
